pc_trace_checker: RTL and testbench

//  Parametrised reset sequencer and program-counter trace checker for core bring-up benches.
//  - Holds the DUT in reset for a configurable number of cycles, then releases it.
//  - Samples the DUT PC on qualified cycles and compares each sample with an arithmetic

---
 rtl/pc_trace_checker_if.sv | 11 +
 rtl/pc_trace_checker.sv | 128 ++++++++++++
 tb/tb_pc_trace_checker.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_trace_checker_if.sv
// PC trace bus between a core's fetch stage and the trace checker.
// The master drives the program counter and its per-cycle qualifier.
interface pc_trace_checker_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic [DATA_W-1:0] pc;
  logic              pc_valid;

  modport master (output pc, output pc_valid);
  modport slave  (input pc, input pc_valid);
endinterface

// File: rtl/pc_trace_checker.sv
// Reset sequencer plus PC trace checker: holds the DUT in reset, then compares sampled PCs
// against start + k*stride. Define PC_TRACE_DISPLAY_EN for per-sample simulation printouts.
module pc_trace_checker #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned RST_CYCLES  = 5,
  parameter int unsigned NUM_SAMPLES = 4,
  parameter logic [31:0] START_VAL   = 32'h0,
  parameter logic [31:0] STRIDE      = 32'h4,
  parameter int unsigned ERR_W       = 8,
  localparam int unsigned CNT_W      = $clog2(NUM_SAMPLES + 1)
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    restart_i,
  pc_trace_checker_if.slave       trace_if,
  output logic                    dut_rst_o,
  output logic                    done_o,
  output logic                    pass_o,
  output logic [ERR_W-1:0]        err_cnt_o,
  output logic [CNT_W-1:0]        sample_cnt_o,
  output logic [CNT_W-1:0]        first_err_idx_o,
  output logic [DATA_W-1:0]       first_err_val_o
);

  localparam int unsigned RCNT_W = $clog2(RST_CYCLES + 1);
  localparam logic [DATA_W-1:0] START_T  = DATA_W'(START_VAL);
  localparam logic [DATA_W-1:0] STRIDE_T = DATA_W'(STRIDE);

  typedef enum logic [1:0] {StResetHold, StSample, StDone} state_e;

  state_e              r_state;
  logic [RCNT_W-1:0]   r_rst_cnt;
  logic                r_dut_rst;
  logic [DATA_W-1:0]   r_exp;
  logic                r_done;
  logic                r_pass;
  logic [ERR_W-1:0]    r_err_cnt;
  logic [CNT_W-1:0]    r_sample_cnt;
  logic [CNT_W-1:0]    r_first_idx;
  logic [DATA_W-1:0]   r_first_val;

  logic                w_mismatch;
  logic                w_last;
  logic [ERR_W-1:0]    w_err_next;

  assign w_mismatch = (trace_if.pc != r_exp);
  assign w_last     = (r_sample_cnt == CNT_W'(NUM_SAMPLES - 1));
  // Error counter sticks at all-ones rather than wrapping back to a passing value.
  assign w_err_next = (w_mismatch && !(&r_err_cnt)) ? r_err_cnt + 1'b1 : r_err_cnt;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state      <= StResetHold;
      r_rst_cnt    <= '0;
      r_dut_rst    <= 1'b1;
      r_exp        <= START_T;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_cnt    <= '0;
      r_sample_cnt <= '0;
      r_first_idx  <= '0;
      r_first_val  <= '0;
    end else if (restart_i) begin
      r_state      <= StResetHold;
      r_rst_cnt    <= '0;
      r_dut_rst    <= 1'b1;
      r_exp        <= START_T;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_cnt    <= '0;
      r_sample_cnt <= '0;
      r_first_idx  <= '0;
      r_first_val  <= '0;
    end else begin
      unique case (r_state)
        StResetHold: begin
          r_rst_cnt <= r_rst_cnt + 1'b1;
          if (r_rst_cnt == RCNT_W'(RST_CYCLES - 1)) begin
            r_state   <= StSample;
            r_dut_rst <= 1'b0;
          end
        end
        StSample: begin
          if (trace_if.pc_valid) begin
            r_sample_cnt <= r_sample_cnt + 1'b1;
            r_exp        <= r_exp + STRIDE_T;
            r_err_cnt    <= w_err_next;
            if (w_mismatch && (r_err_cnt == '0)) begin
              r_first_idx <= r_sample_cnt;
              r_first_val <= trace_if.pc;
            end
            if (w_last) begin
              r_state <= StDone;
              r_done  <= 1'b1;
              r_pass  <= (w_err_next == '0);
            end
          end
        end
        StDone: begin
        end
        default: r_state <= StResetHold;
      endcase
    end
  end

  assign dut_rst_o       = r_dut_rst;
  assign done_o          = r_done;
  assign pass_o          = r_pass;
  assign err_cnt_o       = r_err_cnt;
  assign sample_cnt_o    = r_sample_cnt;
  assign first_err_idx_o = r_first_idx;
  assign first_err_val_o = r_first_val;

`ifdef PC_TRACE_DISPLAY_EN
  always_ff @(posedge clk_i) begin
    if (rstn_i && !restart_i && (r_state == StSample) && trace_if.pc_valid) begin
      $display("pc = %h exp = %h %s", trace_if.pc, r_exp, w_mismatch ? "MISMATCH" : "OK");
      if (w_last) begin
        if (w_err_next == '0) $display("trace passed");
        else                  $display("trace failed, errors = %0d", w_err_next);
      end
    end
  end
`else
  // Trace printouts compiled out; checker behaviour is unchanged.
`endif

endmodule

// File: tb/tb_pc_trace_checker.sv
// Bench for pc_trace_checker: directed vector table, hand-written reset/wrap sequences and
// randomized traffic checked against a sample-list reference model.
module tb_pc_trace_checker;

  localparam int unsigned RST_C = 5;
  localparam int unsigned NUM_S = 4;
  localparam logic [31:0] START = 32'h0;
  localparam logic [31:0] STEP  = 32'h4;

  logic clk = 1'b0;
  logic rstn, restart, restart_w;
  always #5 clk = ~clk;

  pc_trace_checker_if #(.DATA_W(32)) trace_if ();
  pc_trace_checker_if #(.DATA_W(32)) trace_w_if ();

  logic        dut_rst, done, pass;
  logic [7:0]  err_cnt;
  logic [2:0]  sample_cnt, fidx;
  logic [31:0] fval;

  logic        dut_rst_w, done_w, pass_w;
  logic [0:0]  err_cnt_w;
  logic [2:0]  sample_cnt_w, fidx_w;
  logic [31:0] fval_w;

  pc_trace_checker u_dut (
    .clk_i(clk), .rstn_i(rstn), .restart_i(restart), .trace_if(trace_if.slave),
    .dut_rst_o(dut_rst), .done_o(done), .pass_o(pass), .err_cnt_o(err_cnt),
    .sample_cnt_o(sample_cnt), .first_err_idx_o(fidx), .first_err_val_o(fval)
  );

  // Wrap-around start value and a 1-bit error counter to exercise saturation.
  pc_trace_checker #(.START_VAL(32'hFFFF_FFF8), .ERR_W(1)) u_dut_w (
    .clk_i(clk), .rstn_i(rstn), .restart_i(restart_w), .trace_if(trace_w_if.slave),
    .dut_rst_o(dut_rst_w), .done_o(done_w), .pass_o(pass_w), .err_cnt_o(err_cnt_w),
    .sample_cnt_o(sample_cnt_w), .first_err_idx_o(fidx_w), .first_err_val_o(fval_w)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_main(input string tag, input logic e_rst, input logic e_done,
                          input logic e_pass, input int e_err, input int e_cnt,
                          input int e_fidx, input logic [31:0] e_fval);
    chk({tag, ".dut_rst"}, 32'(dut_rst), 32'(e_rst));
    chk({tag, ".done"}, 32'(done), 32'(e_done));
    chk({tag, ".pass"}, 32'(pass), 32'(e_pass));
    chk({tag, ".err_cnt"}, 32'(err_cnt), 32'(e_err));
    chk({tag, ".sample_cnt"}, 32'(sample_cnt), 32'(e_cnt));
    chk({tag, ".first_idx"}, 32'(fidx), 32'(e_fidx));
    chk({tag, ".first_val"}, fval, e_fval);
  endtask

  typedef struct {
    logic        restart;
    logic        valid;
    logic [31:0] pc;
    logic        e_rst;
    logic        e_done;
    logic        e_pass;
    int          e_err;
    int          e_cnt;
    int          e_fidx;
    logic [31:0] e_fval;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, input logic v, input logic [31:0] p, input logic e_rst,
                     input logic e_done, input logic e_pass, input int e_err, input int e_cnt,
                     input int e_fidx, input logic [31:0] e_fval);
    vec_t x;
    x.restart = r; x.valid = v; x.pc = p; x.e_rst = e_rst; x.e_done = e_done;
    x.e_pass = e_pass; x.e_err = e_err; x.e_cnt = e_cnt; x.e_fidx = e_fidx; x.e_fval = e_fval;
    vecs.push_back(x);
  endtask

  // Reset hold as seen after a release/restart: high for four edges, low after the fifth.
  task automatic add_hold(input logic v);
    for (int i = 0; i < int'(RST_C) - 1; i++) add(0, v, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    add(0, v, 32'h0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick(input logic r, input logic v, input logic [31:0] p);
    restart = r; trace_if.pc_valid = v; trace_if.pc = p;
    @(posedge clk); #1;
  endtask

  task automatic tick_w(input logic r, input logic v, input logic [31:0] p);
    restart_w = r; trace_w_if.pc_valid = v; trace_w_if.pc = p;
    @(posedge clk); #1;
  endtask

  // Reference model: edges since (re)start plus the list of accepted PC samples.
  int          m_edges;
  logic [31:0] m_q[$];

  function automatic void m_step(input logic r, input logic v, input logic [31:0] p);
    if (r) begin
      m_edges = 0;
      m_q.delete();
    end else if (m_edges < int'(RST_C)) begin
      m_edges++;
    end else if (v && m_q.size() < int'(NUM_S)) begin
      m_q.push_back(p);
    end
  endfunction

  task automatic m_check(input string tag);
    int          errs = 0;
    int          first_i = 0;
    logic [31:0] first_v = '0;
    logic        m_done;
    for (int i = 0; i < m_q.size(); i++) begin
      if (m_q[i] != START + 32'(i) * STEP) begin
        if (errs == 0) begin
          first_i = i;
          first_v = m_q[i];
        end
        errs++;
      end
    end
    m_done = (m_q.size() == int'(NUM_S));
    chk_main(tag, m_edges < int'(RST_C), m_done, m_done && errs == 0, errs, m_q.size(),
             first_i, first_v);
  endtask

  initial begin
    rstn = 1'b0; restart = 1'b0; restart_w = 1'b0;
    trace_if.pc = '0; trace_if.pc_valid = 1'b0;
    trace_w_if.pc = '0; trace_w_if.pc_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_main("reset", 1, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;

    // Clean trace; valid during hold must be ignored; DONE freezes.
    for (int i = 0; i < int'(RST_C) - 1; i++) add(0, 1, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 32'h0,  0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 32'h4,  0, 0, 0, 0, 2, 0, 0);
    add(0, 1, 32'h8,  0, 0, 0, 0, 3, 0, 0);
    add(0, 1, 32'hC,  0, 1, 1, 0, 4, 0, 0);
    add(0, 1, 32'h55, 0, 1, 1, 0, 4, 0, 0);
    // Restart (held two cycles), then a trace with one bad sample.
    add(1, 1, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    add_hold(0);
    add(0, 1, 32'h0,  0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 32'h4,  0, 0, 0, 0, 2, 0, 0);
    add(0, 1, 32'h10, 0, 0, 0, 1, 3, 2, 32'h10);
    add(0, 1, 32'hC,  0, 1, 0, 1, 4, 2, 32'h10);
    // Restart out of a failed DONE, then a trace with stalls.
    add(1, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    add_hold(0);
    add(0, 1, 32'h0, 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 32'hFFFF, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 32'h4, 0, 0, 0, 0, 2, 0, 0);
    add(0, 1, 32'h8, 0, 0, 0, 0, 3, 0, 0);
    add(0, 1, 32'hC, 0, 1, 1, 0, 4, 0, 0);
    // Restart wins over a simultaneous valid sample.
    add(1, 0, 32'h0, 1, 0, 0, 0, 0, 0, 0);
    add_hold(0);
    add(0, 1, 32'h0, 0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 32'h4, 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      tick(vecs[i].restart, vecs[i].valid, vecs[i].pc);
      chk_main($sformatf("vec%0d", i), vecs[i].e_rst, vecs[i].e_done, vecs[i].e_pass,
               vecs[i].e_err, vecs[i].e_cnt, vecs[i].e_fidx, vecs[i].e_fval);
    end

    // Async reset mid-SAMPLE clears at once, then a full rerun passes.
    repeat (RST_C) tick(0, 0, 32'h0);
    tick(0, 1, 32'h0);
    tick(0, 1, 32'h4);
    chk("async.pre_cnt", 32'(sample_cnt), 32'd2);
    rstn = 1'b0;
    #2;
    chk_main("async.clear", 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (RST_C - 1) tick(0, 0, 32'h0);
    chk("async.still_held", 32'(dut_rst), 32'd1);
    tick(0, 0, 32'h0);
    for (int i = 0; i < int'(NUM_S); i++) tick(0, 1, START + 32'(i) * STEP);
    chk_main("async.rerun", 0, 1, 1, 0, 4, 0, 0);

    // Wrap-around expected sequence.
    tick_w(1, 0, 32'h0);
    repeat (RST_C) tick_w(0, 0, 32'h0);
    tick_w(0, 1, 32'hFFFF_FFF8);
    tick_w(0, 1, 32'hFFFF_FFFC);
    tick_w(0, 1, 32'h0);
    tick_w(0, 1, 32'h4);
    chk("wrap.done", 32'(done_w), 32'd1);
    chk("wrap.pass", 32'(pass_w), 32'd1);
    chk("wrap.err", 32'(err_cnt_w), 32'd0);
    // All samples wrong: 1-bit counter saturates at 1, first mismatch is sample 0.
    tick_w(1, 0, 32'h0);
    repeat (RST_C) tick_w(0, 0, 32'h0);
    tick_w(0, 1, 32'h1);
    tick_w(0, 1, 32'h2);
    tick_w(0, 1, 32'h3);
    tick_w(0, 1, 32'h5);
    chk("sat.err", 32'(err_cnt_w), 32'd1);
    chk("sat.pass", 32'(pass_w), 32'd0);
    chk("sat.done", 32'(done_w), 32'd1);
    chk("sat.fidx", 32'(fidx_w), 32'd0);
    chk("sat.fval", fval_w, 32'h1);

    // Randomized traffic against the model.
    tick(1, 0, 32'h0);
    m_step(1, 0, 32'h0);
    m_check("rand.start");
    for (int c = 0; c < 600; c++) begin
      logic        r, v;
      logic [31:0] p;
      r = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 9) < 6);
      p = ($urandom_range(0, 3) == 0) ? 32'($urandom) : START + 32'(m_q.size()) * STEP;
      tick(r, v, p);
      m_step(r, v, p);
      m_check($sformatf("rand%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
